// File: rtl/multi_cycle_pkg.sv
// multi_cycle_pkg: shared state, opcode and datapath-select encodings for the multi-cycle RV32I controller
package multi_cycle_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I,
        ALU_WB, BRANCH, JAL, JALR, JALR_PC, LUI, HALT
    } state_t;

    typedef logic [6:0] opcode_t;
    typedef logic [2:0] imm_src_t;
    typedef logic [1:0] src_t;
    typedef logic [2:0] alu_fn_t;
    typedef logic [1:0] result_src_t;

    localparam opcode_t OP_LW   = 7'b0000011;
    localparam opcode_t OP_SW   = 7'b0100011;
    localparam opcode_t OP_R    = 7'b0110011;
    localparam opcode_t OP_I    = 7'b0010011;
    localparam opcode_t OP_BR   = 7'b1100011;
    localparam opcode_t OP_JAL  = 7'b1101111;
    localparam opcode_t OP_JALR = 7'b1100111;
    localparam opcode_t OP_LUI  = 7'b0110111;

    localparam imm_src_t IMM_I = 3'b000;
    localparam imm_src_t IMM_S = 3'b001;
    localparam imm_src_t IMM_B = 3'b010;
    localparam imm_src_t IMM_J = 3'b011;
    localparam imm_src_t IMM_U = 3'b100;

    localparam src_t SRCA_PC  = 2'b00;
    localparam src_t SRCA_OLD = 2'b01;
    localparam src_t SRCA_REG = 2'b10;
    localparam src_t SRCB_REG = 2'b00;
    localparam src_t SRCB_IMM = 2'b01;
    localparam src_t SRCB_4   = 2'b10;

    localparam alu_fn_t ALU_ADD = 3'b000;
    localparam alu_fn_t ALU_SUB = 3'b001;
    localparam alu_fn_t ALU_AND = 3'b010;
    localparam alu_fn_t ALU_OR  = 3'b011;
    localparam alu_fn_t ALU_SLT = 3'b100;
    localparam alu_fn_t ALU_XOR = 3'b101;

    localparam result_src_t RES_ALUOUT = 2'b00;
    localparam result_src_t RES_MEM    = 2'b01;
    localparam result_src_t RES_ALU    = 2'b10;
    localparam result_src_t RES_IMM    = 2'b11;

endpackage

// File: rtl/multi_cycle_controller_if.sv
// multi_cycle_controller_if: instruction fields and ALU flags in, datapath enables and selects out
interface multi_cycle_controller_if;
    import multi_cycle_pkg::*;

    opcode_t     opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        zero;
    logic        neg;
    logic        pc_write;
    logic        ir_write;
    logic        adr_src;
    logic        mem_write;
    logic        reg_write;
    imm_src_t    imm_src;
    src_t        alu_src_a;
    src_t        alu_src_b;
    alu_fn_t     alu_function;
    result_src_t result_src;
    logic        halted;

    modport master (
        input  opcode, f3, f7, zero, neg,
        output pc_write, ir_write, adr_src, mem_write, reg_write, imm_src,
               alu_src_a, alu_src_b, alu_function, result_src, halted
    );

    modport slave (
        output opcode, f3, f7, zero, neg,
        input  pc_write, ir_write, adr_src, mem_write, reg_write, imm_src,
               alu_src_a, alu_src_b, alu_function, result_src, halted
    );

endinterface

// File: rtl/multi_cycle_alu_decoder.sv
// multi_cycle_alu_decoder: maps f3/f7 to an ALU function; only R-type honours f7[5] for SUB
module multi_cycle_alu_decoder
    import multi_cycle_pkg::*;
(
    input  logic [2:0] f3_i,
    input  logic [6:0] f7_i,
    input  logic       is_r_i,
    output alu_fn_t    alu_function_o
);

    logic unused_f7;

    assign unused_f7 = ^{f7_i[6], f7_i[4:0]};

    always_comb begin
        alu_function_o = (f3_i == 3'b111) ? ALU_AND :
                         (f3_i == 3'b110) ? ALU_OR  :
                         (f3_i == 3'b010) ? ALU_SLT :
                         (f3_i == 3'b100) ? ALU_XOR :
                         (f3_i == 3'b000 && is_r_i && f7_i[5]) ? ALU_SUB : ALU_ADD;
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: per-instruction state walk driving the shared-ALU, unified-memory RV32I datapath
module multi_cycle_controller
    import multi_cycle_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    multi_cycle_controller_if.master bus
);

    state_t      state_q, state_d;
    logic        pc_w, ir_w, adr, mem_w, reg_w, halt, taken;
    imm_src_t    imm;
    src_t        src_a, src_b;
    alu_fn_t     alu_fn, dec_fn;
    result_src_t res;

    multi_cycle_alu_decoder u_alu_dec (
        .f3_i           (bus.f3),
        .f7_i           (bus.f7),
        .is_r_i         (state_q == EXEC_R),
        .alu_function_o (dec_fn)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        taken = (bus.f3 == 3'b000) ?  bus.zero :
                (bus.f3 == 3'b001) ? ~bus.zero :
                (bus.f3 == 3'b100) ?  bus.neg  :
                (bus.f3 == 3'b101) ? ~bus.neg  : 1'b0;
    end

    always_comb begin
        state_d = state_q;
        pc_w    = 1'b0;
        ir_w    = 1'b0;
        adr     = 1'b0;
        mem_w   = 1'b0;
        reg_w   = 1'b0;
        halt    = 1'b0;
        imm     = IMM_I;
        src_a   = SRCA_PC;
        src_b   = SRCB_REG;
        alu_fn  = ALU_ADD;
        res     = RES_ALUOUT;
        case (state_q)
            FETCH: begin
                ir_w    = 1'b1;
                pc_w    = 1'b1;
                src_b   = SRCB_4;
                res     = RES_ALU;
                state_d = DECODE;
            end
            DECODE: begin
                src_a   = SRCA_OLD;
                src_b   = SRCB_IMM;
                imm     = (bus.opcode == OP_JAL) ? IMM_J : IMM_B;
                state_d = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? MEM_ADR :
                          (bus.opcode == OP_R)    ? EXEC_R :
                          (bus.opcode == OP_I)    ? EXEC_I :
                          (bus.opcode == OP_BR)   ? BRANCH :
                          (bus.opcode == OP_JAL)  ? JAL    :
                          (bus.opcode == OP_JALR) ? JALR   :
                          (bus.opcode == OP_LUI)  ? LUI    : HALT;
            end
            MEM_ADR: begin
                src_a   = SRCA_REG;
                src_b   = SRCB_IMM;
                imm     = (bus.opcode == OP_SW) ? IMM_S : IMM_I;
                state_d = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                adr     = 1'b1;
                state_d = MEM_WB;
            end
            MEM_WB: begin
                res     = RES_MEM;
                reg_w   = 1'b1;
                state_d = FETCH;
            end
            MEM_WRITE: begin
                adr     = 1'b1;
                mem_w   = 1'b1;
                state_d = FETCH;
            end
            EXEC_R: begin
                src_a   = SRCA_REG;
                alu_fn  = dec_fn;
                state_d = ALU_WB;
            end
            EXEC_I: begin
                src_a   = SRCA_REG;
                src_b   = SRCB_IMM;
                alu_fn  = dec_fn;
                state_d = ALU_WB;
            end
            ALU_WB: begin
                reg_w   = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                src_a   = SRCA_REG;
                alu_fn  = ALU_SUB;
                pc_w    = taken;
                state_d = FETCH;
            end
            JAL, JALR_PC: begin
                src_a   = SRCA_OLD;
                src_b   = SRCB_4;
                pc_w    = 1'b1;
                state_d = ALU_WB;
            end
            JALR: begin
                src_a   = SRCA_REG;
                src_b   = SRCB_IMM;
                state_d = JALR_PC;
            end
            LUI: begin
                imm     = IMM_U;
                res     = RES_IMM;
                reg_w   = 1'b1;
                state_d = FETCH;
            end
            HALT: begin
                halt    = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // reset masks every enable combinationally so an asynchronous abort cannot leak a write
    assign bus.pc_write     = pc_w  & ~rst;
    assign bus.ir_write     = ir_w  & ~rst;
    assign bus.mem_write    = mem_w & ~rst;
    assign bus.reg_write    = reg_w & ~rst;
    assign bus.halted       = halt  & ~rst;
    assign bus.adr_src      = adr;
    assign bus.imm_src      = imm;
    assign bus.alu_src_a    = src_a;
    assign bus.alu_src_b    = src_b;
    assign bus.alu_function = alu_fn;
    assign bus.result_src   = res;

endmodule
